neuron_seq_mac: RTL

NEURON_SEQ_MAC -- requirements
Module: neuron_seq_mac

---
 rtl/neuron_pkg.sv | 24 ++
 rtl/neuron_sigmoid_plan.sv | 32 +++
 rtl/neuron_seq_mac.sv | 129 ++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the sequential MAC neuron: FSM states, Q-format and PLAN sigmoid constants.
package neuron_pkg;

    typedef enum logic [1:0] {
        SKUPI = 2'd0,
        AKT   = 2'd1,
        IZLAZ = 2'd2
    } neuron_state_t;

    localparam int Q_FRAC = 8;
    localparam int OUT_W  = 16;

    // PLAN breakpoints as Q8.8 magnitudes: 5.0, 2.375, 1.0
    localparam logic [16:0] PLAN_BP_SAT = 17'd1280;
    localparam logic [16:0] PLAN_BP_MID = 17'd608;
    localparam logic [16:0] PLAN_BP_LOW = 17'd256;

    // Segment offsets in Q0.16: 0.84375, 0.625, 0.5 and 1.0
    localparam logic [16:0] PLAN_OFF_HI  = 17'd55296;
    localparam logic [16:0] PLAN_OFF_MID = 17'd40960;
    localparam logic [16:0] PLAN_OFF_LOW = 17'd32768;
    localparam logic [16:0] PLAN_ONE     = 17'd65536;

endpackage

// File: rtl/neuron_sigmoid_plan.sv
// Combinational PLAN sigmoid approximation: signed Q8.8 in, unsigned Q0.16 out.
module neuron_sigmoid_plan
    import neuron_pkg::*;
(
    input  logic signed [15:0] x,
    output logic        [15:0] y
);

    logic [16:0] mag;
    logic [16:0] y_pos;
    logic [16:0] y_mag;

    always_comb begin
        // 17 bits so that -32768 has a representable magnitude
        mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};

        // Slopes 1/32, 1/8, 1/4 from Q8.8 to Q0.16 become left shifts by 3, 5, 6
        if (mag >= PLAN_BP_SAT) begin
            y_pos = PLAN_ONE;
        end else if (mag >= PLAN_BP_MID) begin
            y_pos = PLAN_OFF_HI + (mag << 3);
        end else if (mag >= PLAN_BP_LOW) begin
            y_pos = PLAN_OFF_MID + (mag << 5);
        end else begin
            y_pos = PLAN_OFF_LOW + (mag << 6);
        end

        y_mag = x[15] ? (PLAN_ONE - y_pos) : y_pos;
        y     = y_mag[16] ? 16'hFFFF : y_mag[15:0];
    end

endmodule

// File: rtl/neuron_seq_mac.sv
// Sequential multiply-accumulate neuron with ReLU output, or PLAN sigmoid when NEURON_SIGMOID_EN is defined.
//
// state | meaning
// SKUPI | collect N_IN beats into the accumulator
// AKT   | rescale accumulator to Q8.8, apply activation, register result
// IZLAZ | present result until the consumer accepts it
module neuron_seq_mac
    import neuron_pkg::*;
#(
    parameter int N_IN  = 60,
    parameter int DW    = 16,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] uzorak,
    input  logic signed [DW-1:0] tezina,
    input  logic signed [DW-1:0] pristranost,
    input  logic                 uzorak_valid,
    output logic                 uzorak_ready,
    output logic [15:0]          izlaz,
    output logic                 izlaz_valid,
    input  logic                 izlaz_ready
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);
    localparam int Q_TOP = Q_FRAC + OUT_W - 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    neuron_state_t state, state_nxt;

    logic [CNT_W-1:0]        beat;
    logic [ACC_W-1:0]        acc;
    logic signed [2*DW-1:0]  prod;
    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        bias_ext;
    logic [ACC_W-1:0]        acc_seed;
    logic [ACC_W:0]          sum_wide;
    logic [ACC_W-1:0]        acc_add;
    logic [ACC_W-1-Q_TOP:0]  acc_hi;
    logic signed [15:0]      q88;
    logic [15:0]             act;
    logic                    beat_fire;

    assign beat_fire = uzorak_valid && (state == SKUPI);

    assign prod     = uzorak * tezina;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DW-Q_FRAC){pristranost[DW-1]}}, pristranost, {Q_FRAC{1'b0}}};

    // The seed cannot overflow: ACC_W leaves room for bias<<8 plus one full product
    assign acc_seed = bias_ext + prod_ext;
    assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

    always_comb begin
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_add = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_add = sum_wide[ACC_W-1:0];
        end
    end

    // Q.16 to Q8.8: the bits above the kept window must all match the sign
    assign acc_hi = acc[ACC_W-1:Q_TOP];

    always_comb begin
        if ((&acc_hi) || (~|acc_hi)) begin
            q88 = acc[Q_TOP:Q_FRAC];
        end else begin
            q88 = acc[ACC_W-1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

`ifdef NEURON_SIGMOID_EN
    neuron_sigmoid_plan u_sigmoid (
        .x (q88),
        .y (act)
    );
`else
    assign act = q88[15] ? 16'h0000 : q88;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SKUPI;
            beat  <= '0;
            acc   <= '0;
            izlaz <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (beat_fire) begin
                acc  <= (beat == '0) ? acc_seed : acc_add;
                beat <= (beat == LAST) ? '0 : beat + CNT_W'(1);
            end
            if (state == AKT) begin
                izlaz <= act;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        uzorak_ready = 1'b0;
        izlaz_valid  = 1'b0;
        case (state)
            SKUPI: begin
                uzorak_ready = 1'b1;
                if (beat_fire && (beat == LAST)) begin
                    state_nxt = AKT;
                end
            end
            AKT: begin
                state_nxt = IZLAZ;
            end
            IZLAZ: begin
                izlaz_valid = 1'b1;
                if (izlaz_ready) begin
                    state_nxt = SKUPI;
                end
            end
            default: begin
                state_nxt = SKUPI;
            end
        endcase
    end

endmodule
